// File: rtl/tp_decision_selector.sv
// tp_decision_selector
// Collects one (degree, root-count) test pattern per accepted beat, builds a
// per-pattern correctable indicator and picks one winning pattern per frame.
// The result is held with a valid/ack handshake.
// Optional build macro: TP_DECISION_SELECTOR_MIN_DEG_EN
//   defined   -> lowest-degree correctable pattern wins (ties keep lower index)
//   undefined -> first correctable pattern in beat order wins
module tp_decision_selector #(
    parameter int TP_NUMS           = 8,
    parameter int BIT_WIDTH_DEG     = 2,
    parameter int BIT_WIDTH_ERR_CNT = 2,
    parameter int DEG_BYPASS        = 2
) (
    input  logic clk,
    input  logic in_ctr_nArst,
    input  logic in_ctr_Srst,
    input  logic in_ctr_start,
    input  logic in_tp_valid,
    input  logic [((BIT_WIDTH_DEG < 1) ? 1 : BIT_WIDTH_DEG)-1:0]         in_tp_deg,
    input  logic [((BIT_WIDTH_ERR_CNT < 1) ? 1 : BIT_WIDTH_ERR_CNT)-1:0] in_tp_errCnt,
    input  logic in_ctr_ack,
    output logic out_busy,
    output logic out_valid,
    output logic [((TP_NUMS < 1) ? 1 : TP_NUMS)-1:0] out_indicTP,
    output logic [((((TP_NUMS < 1) ? 1 : TP_NUMS) > 1) ? $clog2(TP_NUMS) : 1)-1:0] out_selIdx,
    output logic out_fail
);
    localparam int TPN   = (TP_NUMS < 1) ? 1 : TP_NUMS;
    localparam int DW    = (BIT_WIDTH_DEG < 1) ? 1 : BIT_WIDTH_DEG;
    localparam int EW    = (BIT_WIDTH_ERR_CNT < 1) ? 1 : BIT_WIDTH_ERR_CNT;
    localparam int W     = (DW > EW) ? DW : EW;
    localparam int IDX_W = (TPN > 1) ? $clog2(TPN) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic             best_vld;
    logic [W-1:0]     deg_x, err_x;
    logic             ok, win, last_beat, start_frame;
`ifdef TP_DECISION_SELECTOR_MIN_DEG_EN
    logic [W-1:0]     best_deg;
`endif

    // Per-beat classification and selection decision.
    always_comb begin
        deg_x       = W'(in_tp_deg);
        err_x       = W'(in_tp_errCnt);
        ok          = (int'(deg_x) < DEG_BYPASS) || (deg_x == err_x);
        last_beat   = (cnt == IDX_W'(TPN - 1));
        start_frame = in_ctr_start && ((state == IDLE) || ((state == DONE) && in_ctr_ack));
`ifdef TP_DECISION_SELECTOR_MIN_DEG_EN
        // The first correctable pattern always wins, so an all-ones degree
        // that happens to be correctable is not lost against the reset value.
        win = ok && (!best_vld || (deg_x < best_deg));
`else
        win = ok && !best_vld;
`endif
    end

    // Frame FSM; all outputs are the registered state itself.
    always_ff @(posedge clk or negedge in_ctr_nArst) begin
        if (!in_ctr_nArst) begin
            state       <= IDLE;
            cnt         <= '0;
            best_vld    <= 1'b0;
            out_busy    <= 1'b0;
            out_valid   <= 1'b0;
            out_indicTP <= '0;
            out_selIdx  <= '0;
            out_fail    <= 1'b0;
`ifdef TP_DECISION_SELECTOR_MIN_DEG_EN
            best_deg    <= '1;
`endif
        end else if (in_ctr_Srst) begin
            state       <= IDLE;
            cnt         <= '0;
            best_vld    <= 1'b0;
            out_busy    <= 1'b0;
            out_valid   <= 1'b0;
            out_indicTP <= '0;
            out_selIdx  <= '0;
            out_fail    <= 1'b0;
`ifdef TP_DECISION_SELECTOR_MIN_DEG_EN
            best_deg    <= '1;
`endif
        end else begin
            case (state)
                IDLE: ;
                COLLECT: begin
                    if (in_tp_valid) begin
                        out_indicTP[cnt] <= ok;
                        if (win) begin
                            best_vld   <= 1'b1;
                            out_selIdx <= cnt;
`ifdef TP_DECISION_SELECTOR_MIN_DEG_EN
                            best_deg   <= deg_x;
`endif
                        end
                        if (last_beat) begin
                            state     <= DONE;
                            out_busy  <= 1'b0;
                            out_valid <= 1'b1;
                            out_fail  <= ~(best_vld | ok);
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (in_ctr_ack) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_fail  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            // Frame entry (from IDLE, or DONE with ack) overrides the above.
            if (start_frame) begin
                state       <= COLLECT;
                out_busy    <= 1'b1;
                cnt         <= '0;
                best_vld    <= 1'b0;
                out_indicTP <= '0;
                out_selIdx  <= '0;
`ifdef TP_DECISION_SELECTOR_MIN_DEG_EN
                best_deg    <= '1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_tp_decision_selector.sv
// Scoreboard bench for tp_decision_selector: instance A uses default
// parameters, instance B the widened configuration (3/4-bit fields, 5 patterns).
module tb_tp_decision_selector;
    typedef struct packed {
        logic [7:0] indic;
        logic [2:0] sel;
        logic       fail;
    } exp_t;

    logic clk = 0;
    logic nArst = 0, srst = 0;
    always #5 clk = ~clk;

    // Instance A
    logic       a_start = 0, a_tv = 0, a_ack = 0;
    logic [1:0] a_deg = 0, a_err = 0;
    logic       a_busy, a_valid, a_fail;
    logic [7:0] a_indic;
    logic [2:0] a_sel;

    // Instance B
    logic       b_start = 0, b_tv = 0, b_ack = 0;
    logic [2:0] b_deg = 0;
    logic [3:0] b_err = 0;
    logic       b_busy, b_valid, b_fail;
    logic [4:0] b_indic;
    logic [2:0] b_sel;

    int n_tests = 0, n_fail = 0;
    exp_t q_a[$], q_b[$];

    tp_decision_selector u_a (
        .clk(clk), .in_ctr_nArst(nArst), .in_ctr_Srst(srst), .in_ctr_start(a_start),
        .in_tp_valid(a_tv), .in_tp_deg(a_deg), .in_tp_errCnt(a_err), .in_ctr_ack(a_ack),
        .out_busy(a_busy), .out_valid(a_valid), .out_indicTP(a_indic),
        .out_selIdx(a_sel), .out_fail(a_fail)
    );

    tp_decision_selector #(.TP_NUMS(5), .BIT_WIDTH_DEG(3), .BIT_WIDTH_ERR_CNT(4), .DEG_BYPASS(2)) u_b (
        .clk(clk), .in_ctr_nArst(nArst), .in_ctr_Srst(srst), .in_ctr_start(b_start),
        .in_tp_valid(b_tv), .in_tp_deg(b_deg), .in_tp_errCnt(b_err), .in_ctr_ack(b_ack),
        .out_busy(b_busy), .out_valid(b_valid), .out_indicTP(b_indic),
        .out_selIdx(b_sel), .out_fail(b_fail)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop one expected result on every rising edge of out_valid.
    logic pv_a = 0, pv_b = 0;
    always @(negedge clk) begin
        if (a_valid && !pv_a) begin
            if (q_a.size() == 0) chk("A_unexpected_valid", 1, 0);
            else begin
                exp_t e;
                e = q_a.pop_front();
                chk("A_result", {a_indic, a_sel, a_fail}, {e.indic, e.sel, e.fail});
            end
        end
        pv_a = a_valid;
    end
    always @(negedge clk) begin
        if (b_valid && !pv_b) begin
            if (q_b.size() == 0) chk("B_unexpected_valid", 1, 0);
            else begin
                exp_t e;
                e = q_b.pop_front();
                chk("B_result", {3'b000, b_indic, b_sel, b_fail}, {e.indic, e.sel, e.fail});
            end
        end
        pv_b = b_valid;
    end

    task automatic start_a;
        a_start = 1; tick; a_start = 0;
    endtask

    task automatic beat_a(input logic [1:0] d, input logic [1:0] e, input bit bubble);
        a_tv = 1; a_deg = d; a_err = e; tick; a_tv = 0;
        if (bubble) tick;
    endtask

    task automatic wait_valid_a(input string name);
        int i;
        i = 0;
        while (!a_valid && i < 30) begin tick; i++; end
        chk(name, a_valid, 1);
    endtask

    task automatic ack_a;
        a_ack = 1; tick; a_ack = 0;
    endtask

    // Mixed and bubble frames: degree/count pairs packed as {deg,err} nibbles.
    logic [3:0] mixed [8] = '{4'b1110, 4'b1010, 4'b1111, 4'b0000, 4'b1001, 4'b1111, 4'b0111, 4'b1010};
    logic [3:0] bub   [8] = '{4'b1111, 4'b1010, 4'b1101, 4'b0101, 4'b0010, 4'b1100, 4'b1010, 4'b1111};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        tick; tick;
        chk("reset_outputs", {a_busy, a_valid, a_indic, a_sel, a_fail}, 0);
        nArst = 1; tick;

        // Async reset in the middle of a frame
        start_a;
        chk("busy_after_start", a_busy, 1);
        for (int i = 0; i < 3; i++) beat_a(2'd1, 2'd0, 0);
        chk("partial_indic", a_indic, 8'h07);
        nArst = 0; #1;
        chk("async_reset_clears", {a_busy, a_valid, a_indic, a_sel, a_fail}, 0);
        @(posedge clk); #1; nArst = 1; tick;

        // Full frame of bypassed degrees
        e = '{indic: 8'hFF, sel: 3'd0, fail: 1'b0}; q_a.push_back(e);
        start_a;
        for (int i = 0; i < 8; i++) beat_a(2'd1, 2'd0, 0);
        wait_valid_a("valid_all_ok");
        ack_a;

        // Mixed frame: correctable beats 1,2,3,5,6,7 (deg==err or deg<2)
`ifdef TP_DECISION_SELECTOR_MIN_DEG_EN
        e = '{indic: 8'hEE, sel: 3'd3, fail: 1'b0};
`else
        e = '{indic: 8'hEE, sel: 3'd1, fail: 1'b0};
`endif
        q_a.push_back(e);
        start_a;
        for (int i = 0; i < 8; i++) beat_a(mixed[i][3:2], mixed[i][1:0], 0);
        wait_valid_a("valid_mixed");
        ack_a;
        chk("idle_after_ack", {a_busy, a_valid}, 0);

        // Spurious beat in IDLE must not touch the indicator
        a_tv = 1; a_deg = 0; a_err = 0; tick; tick; a_tv = 0;
        chk("idle_beat_ignored", {a_busy, a_indic}, {1'b0, 8'hEE});

        // All-violating frame, result held until ack
        e = '{indic: 8'h00, sel: 3'd0, fail: 1'b1}; q_a.push_back(e);
        start_a;
        for (int i = 0; i < 8; i++) beat_a(2'd2, 2'd3, 0);
        for (int i = 0; i < 5; i++) begin
            chk("valid_held", a_valid, 1);
            tick;
        end
        ack_a;
        chk("fail_cleared_idle", {a_busy, a_valid, a_fail}, 0);

        // Bubbles between every beat
`ifdef TP_DECISION_SELECTOR_MIN_DEG_EN
        e = '{indic: 8'hDB, sel: 3'd4, fail: 1'b0};
`else
        e = '{indic: 8'hDB, sel: 3'd0, fail: 1'b0};
`endif
        q_a.push_back(e);
        start_a;
        for (int i = 0; i < 7; i++) beat_a(bub[i][3:2], bub[i][1:0], 1);
        chk("no_valid_before_last", a_valid, 0);
        beat_a(bub[7][3:2], bub[7][1:0], 0);
        chk("valid_one_after_last", a_valid, 1);

        // Start without ack in DONE is ignored
        a_start = 1; tick; a_start = 0;
        chk("start_no_ack_ignored", {a_busy, a_valid, a_indic}, {1'b0, 1'b1, 8'hDB});

        // Start and ack together restart immediately
        e = '{indic: 8'h00, sel: 3'd0, fail: 1'b1}; q_a.push_back(e);
        a_start = 1; a_ack = 1; tick; a_start = 0; a_ack = 0;
        chk("start_ack_restart", {a_busy, a_valid, a_indic}, {1'b1, 1'b0, 8'h00});
        for (int i = 0; i < 8; i++) beat_a(2'd3, 2'd2, 0);
        wait_valid_a("valid_back_to_back");

        // Sync clear in DONE
        srst = 1; tick; srst = 0;
        chk("srst_in_done", {a_valid, a_fail, a_busy}, 0);

        // Widened instance
`ifdef TP_DECISION_SELECTOR_MIN_DEG_EN
        e = '{indic: 8'h0D, sel: 3'd2, fail: 1'b0};
`else
        e = '{indic: 8'h0D, sel: 3'd0, fail: 1'b0};
`endif
        q_b.push_back(e);
        b_start = 1; tick; b_start = 0;
        chk("B_busy", b_busy, 1);
        b_tv = 1;
        b_deg = 3'd5; b_err = 4'd5;  tick;
        b_deg = 3'd5; b_err = 4'd13; tick;
        b_deg = 3'd1; b_err = 4'd7;  tick;
        b_deg = 3'd7; b_err = 4'd7;  tick;
        b_deg = 3'd4; b_err = 4'd0;  tick;
        b_tv = 0;
        chk("B_valid_after_last", b_valid, 1);
        b_ack = 1; tick; b_ack = 0;
        chk("B_idle", {b_busy, b_valid}, 0);

        tick; tick;
        chk("A_queue_drained", q_a.size(), 0);
        chk("B_queue_drained", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
